ap_handshake_monitor: RTL and testbench

- Synthesizable, parametrised multi-channel successor to the cosim module-status monitor.
- Observes ap_start/ap_ready/ap_done/ap_continue handshakes of NUM_CH HLS modules and tracks per-channel transaction state.
- Measures latency and back-pressure stall per transaction, queues one record per completed transaction in a FIFO, and signals drain completion after finish.
- Sits beside the DUT in cosim or on-chip; a sink drains records through a valid/ready port.

---
 rtl/ap_handshake_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_ap_handshake_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ap_handshake_monitor.sv
// rtl/ap_handshake_monitor.sv - multi-channel ap_* handshake monitor with per-transaction record FIFO
module ap_handshake_monitor #(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = 32,
  parameter int  FIFO_DEPTH = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    finish,
  input  logic [NUM_CH-1:0]       ap_start,
  input  logic [NUM_CH-1:0]       ap_ready,
  input  logic [NUM_CH-1:0]       ap_done,
  input  logic [NUM_CH-1:0]       ap_continue,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [CH_W-1:0]         rec_ch,
  output logic [CNT_W-1:0]        rec_start_cycle,
  output logic [CNT_W-1:0]        rec_latency,
  output logic [CNT_W-1:0]        rec_stall,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [NUM_CH*CNT_W-1:0] txn_count,
  output logic                    overflow,
  output logic                    all_idle,
  output logic                    monitor_done
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = CH_W + 3 * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE_WAIT = 2'd2} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t             state_q    [NUM_CH];
  state_t             state_d    [NUM_CH];
  logic [CNT_W-1:0]   start_q    [NUM_CH];
  logic [CNT_W-1:0]   start_d    [NUM_CH];
  logic [CNT_W-1:0]   stall_q    [NUM_CH];
  logic [CNT_W-1:0]   stall_d    [NUM_CH];
  logic [CNT_W-1:0]   txn_q      [NUM_CH];
  logic [CNT_W-1:0]   txn_d      [NUM_CH];
  logic [REC_W-1:0]   pend_rec_q [NUM_CH];
  logic [REC_W-1:0]   pend_rec_d [NUM_CH];
  logic [NUM_CH-1:0]  pend_valid_q, pend_valid_d, complete;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CH_W-1:0]    rr_q, rr_d, grant_idx;
  logic               grant_valid, grant_en;
  logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic               fifo_full, push, pop;
  logic               overflow_q, overflow_d;
  logic               finish_q, finish_d;
  logic               done_q, done_d;
  logic               all_idle_d;
  logic               unused_ap_ready;

  // ap_ready is observed only; it never steers the channel FSMs
  assign unused_ap_ready = ^ap_ready;

  assign rec_valid = (count_q != '0);
  assign fifo_full = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop       = rec_valid & rec_ready;
  assign push      = grant_en;
  assign {rec_ch, rec_start_cycle, rec_latency, rec_stall} = mem_q[rd_ptr_q];
  assign cycle_count  = cycle_q;
  assign overflow     = overflow_q;
  assign monitor_done = done_q;
  assign cycle_d      = sat_inc(cycle_q);
  assign finish_d     = finish_q | finish;

  // Round-robin pick among full pending registers, starting after the last grant
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_valid && pend_valid_q[(int'(rr_q) + k) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
    grant_en = grant_valid & (~fifo_full | pop);
    rr_d     = grant_en ? CH_W'((int'(grant_idx) + 1) % NUM_CH) : rr_q;
  end

  // Per-channel transaction FSM, measurement counters and pending record slot
  always_comb begin
    overflow_d = overflow_q;
    all_idle_d = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch]  = state_q[ch];
      start_d[ch]  = start_q[ch];
      stall_d[ch]  = stall_q[ch];
      complete[ch] = 1'b0;
      case (state_q[ch])
        S_IDLE: begin
          if (ap_start[ch]) begin
            state_d[ch] = S_BUSY;
            start_d[ch] = cycle_q;
            stall_d[ch] = '0;
          end
        end
        S_BUSY: begin
          if (ap_done[ch]) begin
            if (ap_continue[ch]) begin
              complete[ch] = 1'b1;
              state_d[ch]  = S_IDLE;
            end else begin
              state_d[ch] = S_DONE_WAIT;
              stall_d[ch] = CNT_W'(1);
            end
          end
        end
        S_DONE_WAIT: begin
          if (ap_continue[ch]) begin
            complete[ch] = 1'b1;
            state_d[ch]  = S_IDLE;
          end else begin
            stall_d[ch] = sat_inc(stall_q[ch]);
          end
        end
        default: state_d[ch] = S_IDLE;
      endcase
      txn_d[ch]        = complete[ch] ? sat_inc(txn_q[ch]) : txn_q[ch];
      pend_rec_d[ch]   = pend_rec_q[ch];
      pend_valid_d[ch] = pend_valid_q[ch] & ~(grant_en && (grant_idx == CH_W'(ch)));
      if (complete[ch]) begin
        if (pend_valid_d[ch]) begin
          overflow_d = 1'b1;
        end else begin
          pend_valid_d[ch] = 1'b1;
          pend_rec_d[ch]   = {CH_W'(ch), start_q[ch], cycle_q - start_q[ch], stall_q[ch]};
        end
      end
      if (state_d[ch] != S_IDLE) all_idle_d = 1'b0;
    end
  end

  // Idle summary of the current channel states
  always_comb begin
    all_idle = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (state_q[ch] != S_IDLE) all_idle = 1'b0;
    end
  end

  // Flattened per-channel completed-transaction counters
  always_comb begin
    txn_count = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      txn_count[ch*CNT_W +: CNT_W] = txn_q[ch];
    end
  end

  // FIFO occupancy and drain-complete detection on next-state values
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    done_d = done_q | (finish_d & all_idle_d & ~|pend_valid_d & (count_d == '0));
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= pend_rec_q[grant_idx];
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch]    <= S_IDLE;
        start_q[ch]    <= '0;
        stall_q[ch]    <= '0;
        txn_q[ch]      <= '0;
        pend_rec_q[ch] <= '0;
      end
      pend_valid_q <= '0;
      cycle_q      <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      finish_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch]    <= state_d[ch];
        start_q[ch]    <= start_d[ch];
        stall_q[ch]    <= stall_d[ch];
        txn_q[ch]      <= txn_d[ch];
        pend_rec_q[ch] <= pend_rec_d[ch];
      end
      pend_valid_q <= pend_valid_d;
      cycle_q      <= cycle_d;
      rr_q         <= rr_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      finish_q     <= finish_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_ap_handshake_monitor.sv
// tb/tb_ap_handshake_monitor.sv - scoreboard bench for ap_handshake_monitor
module tb_ap_handshake_monitor;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int CH_W       = 2;

  logic                    clock = 1'b0;
  logic                    reset, finish, rec_ready;
  logic [NUM_CH-1:0]       ap_start, ap_ready, ap_done, ap_continue;
  logic                    rec_valid, overflow, all_idle, monitor_done;
  logic [CH_W-1:0]         rec_ch;
  logic [CNT_W-1:0]        rec_start_cycle, rec_latency, rec_stall, cycle_count;
  logic [NUM_CH*CNT_W-1:0] txn_count;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] stl;
  } rec_t;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ap_handshake_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ch(rec_ch),
    .rec_start_cycle(rec_start_cycle), .rec_latency(rec_latency), .rec_stall(rec_stall),
    .cycle_count(cycle_count), .txn_count(txn_count), .overflow(overflow),
    .all_idle(all_idle), .monitor_done(monitor_done)
  );

  always #5 clock = ~clock;

  function automatic rec_t mk(input int ch, input int st, input int lat, input int stl);
    rec_t r;
    r.ch  = CH_W'(ch);
    r.st  = CNT_W'(st);
    r.lat = CNT_W'(lat);
    r.stl = CNT_W'(stl);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cc(input int n);
    int guard = 0;
    while (cycle_count != CNT_W'(n) && guard < 2000) begin
      tick();
      guard++;
    end
    check("wait_cycle", 64'(cycle_count), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1; finish = 1'b0; ap_start = '0; ap_done = '0; ap_ready = '0; ap_continue = '1;
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  // Scoreboard: each accepted record is compared against the oldest expectation
  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_record: observed ch %0d start %0d expected none", rec_ch, rec_start_cycle);
      end
      if (exp_q.size() != 0) begin
        rec_t e;
        e = exp_q.pop_front();
        check("rec_ch", 64'(rec_ch), 64'(e.ch));
        check("rec_start", 64'(rec_start_cycle), 64'(e.st));
        check("rec_latency", 64'(rec_latency), 64'(e.lat));
        check("rec_stall", 64'(rec_stall), 64'(e.stl));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rec_ready = 1'b0;
    do_reset();
    check("rst_rec_valid", 64'(rec_valid), 0);
    check("rst_overflow", 64'(overflow), 0);
    check("rst_monitor_done", 64'(monitor_done), 0);
    check("rst_all_idle", 64'(all_idle), 1);
    check("rst_cycle_count", 64'(cycle_count), 0);
    check("rst_txn_count", 64'(txn_count != '0), 0);

    // Single channel, continue tied high
    rec_ready = 1'b1;
    wait_cc(10); ap_start[0] = 1'b1;
    tick();      ap_start[0] = 1'b0;
    check("busy_not_idle", 64'(all_idle), 0);
    wait_cc(15); ap_done[0] = 1'b1; exp_q.push_back(mk(0, 10, 5, 0));
    tick();      ap_done[0] = 1'b0;
    check("t1_txn0", 64'(txn_count[0 +: CNT_W]), 1);
    check("t1_valid_c16", 64'(rec_valid), 0);
    tick();
    check("t1_valid_c17", 64'(rec_valid), 1);

    // Back-pressure on ch1
    wait_cc(18); ap_start[1] = 1'b1;
    tick();      ap_start[1] = 1'b0;
    wait_cc(20); ap_done[1] = 1'b1; ap_continue[1] = 1'b0;
    tick();      ap_done[1] = 1'b0;
    wait_cc(23); ap_continue[1] = 1'b1; exp_q.push_back(mk(1, 18, 5, 3));
    tick();
    check("t2_txn1", 64'(txn_count[1*CNT_W +: CNT_W]), 1);
    repeat (4) tick();
    check("t2_drained", 64'(exp_q.size()), 0);

    // Simultaneous completion and round-robin ordering
    do_reset();
    rec_ready = 1'b1;
    wait_cc(25); ap_start = 4'hf;
    tick();      ap_start = 4'h0;
    wait_cc(30); ap_done = 4'hf;
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(mk(i, 25, 5, 0));
    tick();      ap_done = 4'h0;
    wait_cc(40); ap_start[2] = 1'b1;
    tick();      ap_start[2] = 1'b0;
    wait_cc(42); ap_done[2] = 1'b1; exp_q.push_back(mk(2, 40, 2, 0));
    tick();      ap_done[2] = 1'b0;
    wait_cc(44); ap_start = 4'b1010;
    tick();      ap_start = 4'h0;
    wait_cc(47); ap_done = 4'b1010;
    exp_q.push_back(mk(3, 44, 3, 0));
    exp_q.push_back(mk(1, 44, 3, 0));
    tick();      ap_done = 4'h0;
    repeat (5) tick();
    check("t3_drained", 64'(exp_q.size()), 0);

    // FIFO fill, pending slot, then overflow
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wait_cc(10 + 4 * i); ap_start[0] = 1'b1;
      tick();              ap_start[0] = 1'b0;
      wait_cc(12 + 4 * i); ap_done[0] = 1'b1;
      if (i < 17) exp_q.push_back(mk(0, 10 + 4 * i, 2, 0));
      if (i == 17) check("t4_no_overflow_yet", 64'(overflow), 0);
      tick();              ap_done[0] = 1'b0;
    end
    tick();
    check("t4_overflow", 64'(overflow), 1);
    check("t4_txn0", 64'(txn_count[0 +: CNT_W]), 18);
    check("t4_valid", 64'(rec_valid), 1);
    rec_ready = 1'b1;
    repeat (22) tick();
    check("t4_drained", 64'(exp_q.size()), 0);
    check("t4_empty", 64'(rec_valid), 0);

    // Finish with two queued records, then drain
    rec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ap_start[3] = 1'b1;
      exp_q.push_back(mk(3, int'(cycle_count), 2, 0));
      tick(); ap_start[3] = 1'b0;
      tick(); ap_done[3] = 1'b1;
      tick(); ap_done[3] = 1'b0;
      tick();
    end
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
    check("t5_done_while_queued", 64'(monitor_done), 0);
    check("t5_queued", 64'(rec_valid), 1);
    rec_ready = 1'b1;
    for (int g = 0; g < 10 && exp_q.size() != 0; g++) tick();
    check("t5_drained", 64'(exp_q.size()), 0);
    check("t5_done_rise", 64'(monitor_done), 1);
    rec_ready = 1'b0;
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    check("t5_done_sticky", 64'(monitor_done), 1);
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;

    // Reset mid-transaction with records queued
    for (int i = 0; i < 3; i++) begin
      ap_start[1] = 1'b1;
      tick(); ap_start[1] = 1'b0;
      tick(); ap_done[1] = 1'b1;
      tick(); ap_done[1] = 1'b0;
      tick();
    end
    ap_start[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0;
    tick();
    check("t6_pre_valid", 64'(rec_valid), 1);
    check("t6_pre_busy", 64'(all_idle), 0);
    check("t6_pre_overflow", 64'(overflow), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("t6_rec_valid", 64'(rec_valid), 0);
    check("t6_all_idle", 64'(all_idle), 1);
    check("t6_txn_count", 64'(txn_count != '0), 0);
    check("t6_cycle_count", 64'(cycle_count), 0);
    check("t6_overflow", 64'(overflow), 0);
    check("t6_monitor_done", 64'(monitor_done), 0);
    tick();
    check("t6_cycle_run", 64'(cycle_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
